// File: rtl/banco_registros_pkg.sv
// Shared widths and constants for the register file, the ALU and the pipeline stages.
// Importers see one definition of the register-address and data-word formats.
package banco_registros_pkg;

    localparam int ANCHO    = 32;
    localparam int DIR      = 5;
    localparam int NREG     = 1 << DIR;
    localparam int REG_CERO = 0;

    typedef logic [DIR-1:0]   dir_reg_t;
    typedef logic [ANCHO-1:0] palabra_t;

    function automatic logic es_reg_cero(input dir_reg_t d);
        return d == dir_reg_t'(REG_CERO);
    endfunction

endpackage

// File: rtl/banco_registros_puerto_lectura.sv
// One registered read port: zero-register check, write-through bypass and a
// stall-holdable output register.
module puerto_lectura
    import banco_registros_pkg::*;
#(
    parameter int ANCHO = banco_registros_pkg::ANCHO,
    parameter int DIR   = banco_registros_pkg::DIR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retener,
    input  logic [DIR-1:0]   dirLec,
    input  logic [ANCHO-1:0] datoMem,
    input  logic             habEsc,
    input  logic [DIR-1:0]   dirEsc,
    input  logic [ANCHO-1:0] datoEsc,
    output logic [ANCHO-1:0] dato
);

    logic [ANCHO-1:0] dato_p0;
    logic [ANCHO-1:0] dato_p1;

    // A write landing on the address being read wins over the stored copy.
    function automatic logic [ANCHO-1:0] elegir_fuente(
        input logic [DIR-1:0]   lec,
        input logic [ANCHO-1:0] mem_val,
        input logic             we,
        input logic [DIR-1:0]   esc,
        input logic [ANCHO-1:0] esc_val
    );
        if (lec == DIR'(REG_CERO))
            return '0;
        else if (we && (esc == lec))
            return esc_val;
        else
            return mem_val;
    endfunction

    always_comb begin
        dato_p0 = elegir_fuente(dirLec, datoMem, habEsc, dirEsc, datoEsc);
    end

    // Stage boundary: operand register feeding the ALU.
    always_ff @(posedge clk) begin
        if (reset)
            dato_p1 <= '0;
        else if (!retener)
            dato_p1 <= dato_p0;
    end

    assign dato = dato_p1;

endmodule

// File: rtl/banco_registros.sv
// 32x32 general-purpose register file with r0 tied to zero, two registered
// read ports with write-through bypass, stall hold, and a combinational debug port.
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter int ANCHO = banco_registros_pkg::ANCHO,
    parameter int NREG  = banco_registros_pkg::NREG,
    parameter int DIR   = banco_registros_pkg::DIR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIR-1:0]   dirLec1,
    input  logic [DIR-1:0]   dirLec2,
    input  logic             retener,
    input  logic             habEsc,
    input  logic [DIR-1:0]   dirEsc,
    input  logic [ANCHO-1:0] datoEsc,
    output logic [ANCHO-1:0] dato1,
    output logic [ANCHO-1:0] dato2,
    input  logic [DIR-1:0]   dirDep,
    output logic [ANCHO-1:0] datoDep
);

    logic [ANCHO-1:0] regs_q [NREG];
    logic [ANCHO-1:0] vista  [NREG];
    logic [ANCHO-1:0] mem_lec1;
    logic [ANCHO-1:0] mem_lec2;

    // Reset wins over any write presented in the same cycle; r0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else if (habEsc && (dirEsc != DIR'(REG_CERO))) begin
            regs_q[dirEsc] <= datoEsc;
        end
    end

    // Committed view of the file, with r0 forced to zero regardless of storage.
    always_comb begin
        for (int i = 0; i < NREG; i++)
            vista[i] = (i == REG_CERO) ? '0 : regs_q[i];
    end

    always_comb begin
        mem_lec1 = vista[dirLec1];
        mem_lec2 = vista[dirLec2];
        datoDep  = vista[dirDep];
    end

    puerto_lectura #(
        .ANCHO (ANCHO),
        .DIR   (DIR)
    ) u_puerto1 (
        .clk     (clk),
        .reset   (reset),
        .retener (retener),
        .dirLec  (dirLec1),
        .datoMem (mem_lec1),
        .habEsc  (habEsc),
        .dirEsc  (dirEsc),
        .datoEsc (datoEsc),
        .dato    (dato1)
    );

    puerto_lectura #(
        .ANCHO (ANCHO),
        .DIR   (DIR)
    ) u_puerto2 (
        .clk     (clk),
        .reset   (reset),
        .retener (retener),
        .dirLec  (dirLec2),
        .datoMem (mem_lec2),
        .habEsc  (habEsc),
        .dirEsc  (dirEsc),
        .datoEsc (datoEsc),
        .dato    (dato2)
    );

endmodule

// File: tb/tb_banco_registros.sv
// Bench for banco_registros: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an array-based model.
module tb_banco_registros;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dirLec1, dirLec2, dirEsc, dirDep;
    logic        retener, habEsc;
    logic [31:0] datoEsc;
    logic [31:0] dato1, dato2, datoDep;

    int checks = 0;
    int errors = 0;

    // Behavioural model: committed contents and expected port outputs.
    logic [31:0] modelo [32];
    logic [31:0] esp1, esp2;
    bit          modelo_valido = 1'b0;

    always #5 clk = ~clk;

    banco_registros dut (
        .clk     (clk),
        .reset   (reset),
        .dirLec1 (dirLec1),
        .dirLec2 (dirLec2),
        .retener (retener),
        .habEsc  (habEsc),
        .dirEsc  (dirEsc),
        .datoEsc (datoEsc),
        .dato1   (dato1),
        .dato2   (dato2),
        .dirDep  (dirDep),
        .datoDep (datoDep)
    );

    task automatic comparar(input string nombre, input logic [31:0] obtenido,
                            input logic [31:0] esperado);
        checks++;
        if (obtenido !== esperado) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nombre, obtenido, esperado, $time);
        end
    endtask

    function automatic logic [31:0] leer_modelo(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (habEsc && dirEsc == a) return datoEsc;
        return modelo[a];
    endfunction

    // Applies inputs for one clock, advances the model at the edge, returns mid-low-phase.
    task automatic ciclo(input bit rst, input logic [4:0] l1, input logic [4:0] l2,
                         input bit ret, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] dd);
        reset = rst; dirLec1 = l1; dirLec2 = l2; retener = ret;
        habEsc = we; dirEsc = wa; datoEsc = wd; dirDep = dd;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) modelo[i] = 32'h0;
            esp1 = 32'h0;
            esp2 = 32'h0;
            modelo_valido = 1'b1;
        end else begin
            if (!retener) begin
                esp1 = leer_modelo(dirLec1);
                esp2 = leer_modelo(dirLec2);
            end
            if (habEsc && dirEsc != 5'd0) modelo[dirEsc] = datoEsc;
        end
        @(negedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model once it has seen a reset.
    always @(negedge clk) begin
        if (modelo_valido) begin
            comparar("dato1_model", dato1, esp1);
            comparar("dato2_model", dato2, esp2);
            comparar("datoDep_model", datoDep, (dirDep == 5'd0) ? 32'h0 : modelo[dirDep]);
        end
    end

    initial begin
        reset = 1'b0; dirLec1 = '0; dirLec2 = '0; retener = 1'b0;
        habEsc = 1'b0; dirEsc = '0; datoEsc = '0; dirDep = '0;

        ciclo(1, 0, 0, 0, 0, 0, 32'h0, 0);
        comparar("reset_dato1", dato1, 32'h0);
        comparar("reset_dato2", dato2, 32'h0);

        // Reset clears a previously written register.
        ciclo(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 5);
        comparar("pre_reset_dep_r5", datoDep, 32'hDEADBEEF);
        ciclo(1, 5, 5, 0, 0, 0, 32'h0, 5);
        ciclo(0, 5, 5, 0, 0, 0, 32'h0, 5);
        comparar("post_reset_dato1_r5", dato1, 32'h0);
        comparar("post_reset_dato2_r5", dato2, 32'h0);
        comparar("post_reset_dep_r5", datoDep, 32'h0);

        // Basic write then read on both ports.
        ciclo(0, 0, 0, 0, 1, 3, 32'h7, 0);
        ciclo(0, 0, 0, 0, 1, 4, 32'h2, 0);
        ciclo(0, 3, 4, 0, 0, 0, 32'h0, 3);
        comparar("read_r3", dato1, 32'h7);
        comparar("read_r4", dato2, 32'h2);
        comparar("alu_sub_operands", dato1 - dato2, 32'h5);

        // Writes to r0 are dropped.
        ciclo(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0);
        ciclo(0, 0, 0, 0, 0, 0, 32'h0, 0);
        comparar("r0_dato1", dato1, 32'h0);
        comparar("r0_dato2", dato2, 32'h0);
        comparar("r0_dep", datoDep, 32'h0);

        // Bypass on both ports from one write.
        ciclo(0, 0, 0, 0, 1, 8, 32'h11111111, 8);
        ciclo(0, 8, 8, 0, 1, 8, 32'h22222222, 8);
        comparar("bypass_dato1", dato1, 32'h22222222);
        comparar("bypass_dato2", dato2, 32'h22222222);

        // Stall holds outputs while the write still commits.
        ciclo(0, 0, 0, 0, 1, 2, 32'hA, 0);
        ciclo(0, 2, 0, 0, 0, 0, 32'h0, 2);
        comparar("stall_pre_dato1", dato1, 32'hA);
        ciclo(0, 2, 0, 1, 1, 2, 32'hB, 2);
        comparar("stall_hold_dato1", dato1, 32'hA);
        comparar("stall_dep_r2", datoDep, 32'hB);
        ciclo(0, 2, 0, 1, 0, 0, 32'h0, 2);
        comparar("stall_hold2_dato1", dato1, 32'hA);
        ciclo(0, 2, 0, 0, 0, 0, 32'h0, 2);
        comparar("stall_release_dato1", dato1, 32'hB);

        // Reset discards a write in the same cycle.
        ciclo(1, 0, 0, 0, 1, 9, 32'h5, 9);
        ciclo(0, 9, 9, 0, 0, 0, 32'h0, 9);
        comparar("reset_write_dato1", dato1, 32'h0);
        comparar("reset_write_dep", datoDep, 32'h0);

        // Randomized traffic, addresses often confined to a small window to provoke bypass.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] l1, l2, wa, dd;
            bit estrecho;
            estrecho = ($urandom_range(0, 1) == 1);
            l1 = estrecho ? 5'($urandom_range(0, 3)) : 5'($urandom);
            l2 = estrecho ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa = estrecho ? 5'($urandom_range(0, 3)) : 5'($urandom);
            dd = 5'($urandom);
            ciclo(($urandom_range(0, 199) == 0), l1, l2, ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 2) != 0), wa, $urandom, dd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
